// File: rtl/spi_burst_master.sv
// spi_burst_master: CS-framed SPI burst engine, 1..MAX_LEN words of DATA_W bits.
// Define SPI_LOOPBACK_EN to add the loopback port (sample mosi instead of miso).
module spi_burst_master #(
  parameter int DATA_W   = 8,
  parameter int CLK_DIV  = 4,
  parameter bit CPOL     = 1'b1,
  parameter bit CPHA     = 1'b1,
  parameter int MAX_LEN  = 8,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 4,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
`ifdef SPI_LOOPBACK_EN
  input  logic              loopback,
`endif
  output logic              cs_n
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDG_W = $clog2(2 * DATA_W + 1);
  localparam int T_A   = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int T_MAX = (T_A > CS_IDLE) ? T_A : CS_IDLE;
  localparam int TCN_W = $clog2(T_MAX + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  logic [2:0]        r_state;
  logic              r_cs_n;
  logic              r_sclk;
  logic              r_mosi;
  logic              r_busy;
  logic              r_done;
  logic              r_rx_valid;
  logic [DATA_W-1:0] r_rx_data;
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_wcnt;
  logic [DIV_W-1:0]  r_div;
  logic [EDG_W-1:0]  r_edge;
  logic [TCN_W-1:0]  r_tcnt;

  logic              w_sin;
  logic              w_lead;
  logic              w_smp;
  logic              w_tick;
  logic              w_last;
  logic [LEN_W-1:0]  w_len;
  logic [DATA_W-1:0] w_rx_nxt;

`ifdef SPI_LOOPBACK_EN
  assign w_sin = loopback ? r_mosi : miso;
`else
  assign w_sin = miso;
`endif

  // even edge index = leading edge; sample on leading when CPHA=0
  assign w_lead   = ~r_edge[0];
  assign w_smp    = w_lead ^ CPHA;
  assign w_tick   = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_last   = (r_edge == EDG_W'(2 * DATA_W - 1));
  assign w_rx_nxt = {r_rx[DATA_W-2:0], w_sin};
  assign w_len    = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cs_n     <= 1'b1;
      r_sclk     <= CPOL;
      r_mosi     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_len      <= '0;
      r_wcnt     <= '0;
      r_div      <= '0;
      r_edge     <= '0;
      r_tcnt     <= '0;
    end else begin
      r_done     <= 1'b0;
      r_rx_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start && !r_done) begin
            r_busy <= 1'b1;
            r_wcnt <= '0;
            if (len == '0) begin
              r_tcnt  <= TCN_W'(CS_IDLE - 1);
              r_state <= S_GAP;
            end else begin
              r_tcnt  <= '0;
              r_len   <= w_len;
              r_cs_n  <= 1'b0;
              r_state <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          if (r_tcnt == TCN_W'(CS_SETUP - 1)) begin
            r_tcnt  <= '0;
            r_state <= S_LOAD;
          end else begin
            r_tcnt <= r_tcnt + TCN_W'(1);
          end
        end
        S_LOAD: begin
          if (tx_valid) begin
            r_tx    <= CPHA ? tx_data : (tx_data << 1);
            r_rx    <= '0;
            r_div   <= '0;
            r_edge  <= '0;
            r_state <= S_SHIFT;
            if (!CPHA) r_mosi <= tx_data[DATA_W-1];
          end
        end
        S_SHIFT: begin
          if (w_tick) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
            r_edge <= r_edge + EDG_W'(1);
            if (w_smp) begin
              r_rx <= w_rx_nxt;
            end else begin
              r_mosi <= r_tx[DATA_W-1];
              r_tx   <= r_tx << 1;
            end
            if (w_last) begin
              r_rx_valid <= 1'b1;
              r_rx_data  <= w_smp ? w_rx_nxt : r_rx;
              r_tcnt     <= '0;
              if (r_wcnt == r_len - LEN_W'(1)) begin
                r_state <= S_HOLD;
              end else begin
                r_wcnt  <= r_wcnt + LEN_W'(1);
                r_state <= S_LOAD;
              end
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        S_HOLD: begin
          if (r_tcnt == TCN_W'(CS_HOLD - 1)) begin
            r_cs_n  <= 1'b1;
            r_tcnt  <= '0;
            r_state <= S_GAP;
          end else begin
            r_tcnt <= r_tcnt + TCN_W'(1);
          end
        end
        S_GAP: begin
          if (r_tcnt == TCN_W'(CS_IDLE - 1)) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_tcnt <= r_tcnt + TCN_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign tx_ready = (r_state == S_LOAD);
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign sclk     = r_sclk;
  assign mosi     = r_mosi;
  assign cs_n     = r_cs_n;

endmodule

// File: tb/tb_spi_burst_master.sv
// tb_spi_burst_master: all four SPI modes run in lockstep against a
// bit-stream device model; bursts checked against expected word streams.
`timescale 1ns/1ps
module tb_spi_burst_master;
  localparam int W    = 8;
  localparam int MAXL = 8;
  localparam int NM   = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    len = '0;
  logic [W-1:0]  tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          loop = 1'b0;
  logic [NM-1:0] busy, done, tx_ready, rx_valid;
  logic [NM-1:0] sclk, mosi, miso, cs_n, dbit;
  logic [W-1:0]  rx_data [NM];

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] txw [16];
  logic [W-1:0] devw [16];
  logic [W-1:0] rxq [NM][$];
  logic [W-1:0] mq [NM][$];
  logic [W-1:0] mw [NM];
  int           n_done [NM];
  int           n_edge [NM];
  int           n_csf [NM];
  int           bi [NM];
  int           mn [NM];
  logic         p_cs [NM];
  logic         p_sclk [NM];

  always #5 clk = ~clk;
  assign miso = loop ? mosi : dbit;

  for (genvar g = 0; g < NM; g++) begin : g_dut
    spi_burst_master #(
      .DATA_W(W), .CLK_DIV(4),
      .CPOL(1'((g >> 1) & 1)), .CPHA(1'(g & 1)),
      .MAX_LEN(MAXL), .CS_SETUP(2), .CS_HOLD(2), .CS_IDLE(4)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len),
      .busy(busy[g]), .done(done[g]),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready[g]),
      .rx_data(rx_data[g]), .rx_valid(rx_valid[g]),
      .sclk(sclk[g]), .mosi(mosi[g]), .miso(miso[g]),
`ifdef SPI_LOOPBACK_EN
      .loopback(1'b0),
`endif
      .cs_n(cs_n[g])
    );
  end

`ifdef SPI_LOOPBACK_EN
  logic        s6_start = 1'b0;
  logic        s6_txv = 1'b0;
  logic [15:0] s6_tx = '0;
  logic        s6_busy, s6_done, s6_rdy, s6_rxv, s6_sclk, s6_mosi, s6_cs;
  logic [15:0] s6_rx;
  spi_burst_master #(.DATA_W(16)) u_lb (
    .clk(clk), .rst_n(rst_n), .start(s6_start), .len(4'd1),
    .busy(s6_busy), .done(s6_done),
    .tx_data(s6_tx), .tx_valid(s6_txv), .tx_ready(s6_rdy),
    .rx_data(s6_rx), .rx_valid(s6_rxv),
    .sclk(s6_sclk), .mosi(s6_mosi), .miso(1'b0),
    .loopback(1'b1), .cs_n(s6_cs)
  );
`endif

  function automatic logic pol_of(int g);
    return 1'((g >> 1) & 1);
  endfunction

  function automatic logic pha_of(int g);
    return 1'(g & 1);
  endfunction

  function automatic logic devbit(int i);
    logic [W-1:0] w;
    if (i >= 16 * W) return 1'b0;
    w = devw[i / W];
    return w[W - 1 - (i % W)];
  endfunction

  // SPI slave: MSB-first bit stream out, mosi words captured in
  always @(negedge clk) begin
    for (int g = 0; g < NM; g++) begin
      if (!rst_n) begin
        p_cs[g]   = 1'b1;
        p_sclk[g] = pol_of(g);
        dbit[g]   = 1'b0;
      end else begin
        if (rx_valid[g]) rxq[g].push_back(rx_data[g]);
        if (done[g]) n_done[g]++;
        if (p_cs[g] && !cs_n[g]) begin
          n_csf[g]++;
          mn[g] = 0;
          bi[g] = 0;
          if (!pha_of(g)) begin
            dbit[g] = devbit(0);
            bi[g]   = 1;
          end
        end
        if (!cs_n[g] && sclk[g] !== p_sclk[g]) begin
          n_edge[g]++;
          if ((sclk[g] != pol_of(g)) ^ pha_of(g)) begin
            mw[g] = {mw[g][W-2:0], mosi[g]};
            mn[g]++;
            if (mn[g] % W == 0) mq[g].push_back(mw[g]);
          end else begin
            dbit[g] = devbit(bi[g]);
            bi[g]++;
          end
        end
        p_cs[g]   = cs_n[g];
        p_sclk[g] = sclk[g];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 16; i++) begin
      txw[i]  = W'($urandom);
      devw[i] = W'($urandom);
    end
  endtask

  task automatic burst(input int n, input bit lp, input int stall_w);
    int m, k, cyc;
    int b_rx [NM];
    int b_mq [NM];
    int b_dn [NM];
    int b_ed [NM];
    int b_cs [NM];
    logic [W-1:0] obs, want;
    m = (n > MAXL) ? MAXL : n;
    for (int g = 0; g < NM; g++) begin
      b_rx[g] = rxq[g].size();
      b_mq[g] = mq[g].size();
      b_dn[g] = n_done[g];
      b_ed[g] = n_edge[g];
      b_cs[g] = n_csf[g];
      chk($sformatf("idle_pre_m%0d", g), 32'(sclk[g]), 32'(pol_of(g)));
    end
    loop = lp;
    k = 0;
    @(negedge clk);
    start = 1'b1;
    len = 4'(n);
    tx_data = txw[0];
    tx_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy[0] === 1'b1 && cyc < 4000) begin
      if (tx_ready[0] && tx_valid) begin
        k++;
        @(posedge clk);
        #1;
        tx_data = txw[k % 16];
        if (k == stall_w) begin
          tx_valid = 1'b0;
          repeat (120) @(negedge clk);
          for (int g = 0; g < NM; g++) begin
            chk($sformatf("stall_sclk_m%0d", g), 32'(sclk[g]), 32'(pol_of(g)));
            chk($sformatf("stall_cs_m%0d", g), 32'(cs_n[g]), 32'd0);
            chk($sformatf("stall_rdy_m%0d", g), 32'(tx_ready[g]), 32'd1);
          end
          tx_valid = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    chk("burst_bound", 32'(cyc < 4000), 32'd1);
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < NM; g++) begin
      chk($sformatf("rx_cnt_m%0d", g), 32'(rxq[g].size() - b_rx[g]), 32'(m));
      chk($sformatf("mo_cnt_m%0d", g), 32'(mq[g].size() - b_mq[g]), 32'(m));
      for (int i = 0; i < m; i++) begin
        want = lp ? txw[i] : devw[i];
        obs = (b_rx[g] + i < rxq[g].size()) ? rxq[g][b_rx[g] + i] : 'x;
        chk($sformatf("rx%0d_m%0d", i, g), 32'(obs), 32'(want));
        obs = (b_mq[g] + i < mq[g].size()) ? mq[g][b_mq[g] + i] : 'x;
        chk($sformatf("mosi%0d_m%0d", i, g), 32'(obs), 32'(txw[i]));
      end
      chk($sformatf("done_m%0d", g), 32'(n_done[g] - b_dn[g]), 32'd1);
      chk($sformatf("edges_m%0d", g), 32'(n_edge[g] - b_ed[g]), 32'(2 * W * m));
      chk($sformatf("csfall_m%0d", g), 32'(n_csf[g] - b_cs[g]), 32'd1);
      chk($sformatf("idle_post_m%0d", g), 32'(sclk[g]), 32'(pol_of(g)));
      chk($sformatf("cs_post_m%0d", g), 32'(cs_n[g]), 32'd1);
      chk($sformatf("busy_post_m%0d", g), 32'(busy[g]), 32'd0);
    end
  endtask

  task automatic zero_len();
    int b_dn [NM];
    int b_cs [NM];
    for (int g = 0; g < NM; g++) begin
      b_dn[g] = n_done[g];
      b_cs[g] = n_csf[g];
    end
    @(negedge clk);
    start = 1'b1;
    len = 4'd0;
    @(negedge clk);
    start = 1'b0;
    for (int g = 0; g < NM; g++) begin
      chk($sformatf("z_busy1_m%0d", g), 32'(busy[g]), 32'd1);
      chk($sformatf("z_done1_m%0d", g), 32'(done[g]), 32'd0);
    end
    @(negedge clk);
    for (int g = 0; g < NM; g++) begin
      chk($sformatf("z_done2_m%0d", g), 32'(done[g]), 32'd1);
      chk($sformatf("z_busy2_m%0d", g), 32'(busy[g]), 32'd0);
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < NM; g++) begin
      chk($sformatf("z_csf_m%0d", g), 32'(n_csf[g] - b_cs[g]), 32'd0);
      chk($sformatf("z_dn_m%0d", g), 32'(n_done[g] - b_dn[g]), 32'd1);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    for (int g = 0; g < NM; g++) begin
      chk($sformatf("rst_cs_m%0d", g), 32'(cs_n[g]), 32'd1);
      chk($sformatf("rst_sclk_m%0d", g), 32'(sclk[g]), 32'(pol_of(g)));
      chk($sformatf("rst_mosi_m%0d", g), 32'(mosi[g]), 32'd0);
      chk($sformatf("rst_busy_m%0d", g), 32'(busy[g]), 32'd0);
      chk($sformatf("rst_done_m%0d", g), 32'(done[g]), 32'd0);
      chk($sformatf("rst_rdy_m%0d", g), 32'(tx_ready[g]), 32'd0);
      chk($sformatf("rst_rxv_m%0d", g), 32'(rx_valid[g]), 32'd0);
      chk($sformatf("rst_rxd_m%0d", g), 32'(rx_data[g]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    fill_rand();
    txw[0] = 8'hE8;
    txw[1] = 8'h00;
    devw[0] = 8'hA5;
    devw[1] = 8'h3C;
    burst(2, 1'b0, -1);

    fill_rand();
    burst(2, 1'b0, 1);

    fill_rand();
    txw[0] = 8'h96;
    burst(1, 1'b1, -1);

    zero_len();

    fill_rand();
    burst(MAXL + 3, 1'b0, -1);

    repeat (4) begin
      fill_rand();
      burst(int'($urandom_range(1, MAXL)), 1'($urandom_range(0, 1)), -1);
    end

    fill_rand();
    loop = 1'b0;
    @(negedge clk);
    start = 1'b1;
    len = 4'd3;
    tx_data = txw[0];
    tx_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    chk("pre_rst_busy", 32'(busy[0]), 32'd1);
    chk("pre_rst_cs", 32'(cs_n[0]), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    for (int g = 0; g < NM; g++) begin
      chk($sformatf("arst_cs_m%0d", g), 32'(cs_n[g]), 32'd1);
      chk($sformatf("arst_sclk_m%0d", g), 32'(sclk[g]), 32'(pol_of(g)));
      chk($sformatf("arst_busy_m%0d", g), 32'(busy[g]), 32'd0);
    end
    tx_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    fill_rand();
    burst(1, 1'b0, -1);

`ifdef SPI_LOOPBACK_EN
    begin
      int cyc;
      @(negedge clk);
      s6_start = 1'b1;
      s6_tx = 16'hBEEF;
      s6_txv = 1'b1;
      @(negedge clk);
      s6_start = 1'b0;
      cyc = 0;
      while (s6_rxv !== 1'b1 && cyc < 1000) begin
        @(negedge clk);
        cyc++;
      end
      chk("lb_bound", 32'(cyc < 1000), 32'd1);
      chk("lb_rx", 32'(s6_rx), 32'h0000BEEF);
      s6_txv = 1'b0;
      repeat (20) @(negedge clk);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
